// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, field widths and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_lite_pkg;

  // Response code carried on B and R.
  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam int unsigned PROT_W = 3;
  localparam int unsigned RESP_W = 2;

  // One strobe bit per data byte; only 32- and 64-bit data are meaningful.
  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite link bundle (AW, W, B, AR, R) with master/slave views.
// Latency: n/a (wiring only).
// Backpressure: plain valid/ready on every channel.
interface axi_lite_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  import axi_lite_pkg::*;

  localparam int unsigned STRB_W = strb_w(DATA_WIDTH);

  // Write address
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [PROT_W-1:0]     awprot;
  // Write data
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  // Write response
  logic                  bvalid;
  logic                  bready;
  resp_t                 bresp;
  // Read address
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [PROT_W-1:0]     arprot;
  // Read data
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  resp_t                 rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );

endinterface

// File: rtl/axi_skid_buffer.sv
// Two-entry (main + skid) valid/ready register stage; BYPASS=1 turns it into wires.
// Latency: 1 cycle in->out registered, 0 cycles in bypass.
// Backpressure: in_ready is a flop equal to !skid_valid; held low in reset, high the first edge after.
module axi_skid_buffer #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire;
  logic             out_fire;

  // Next-state: drain main (refill from skid), then place any accepted beat.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    in_fire      = in_valid && in_ready_q;
    out_fire     = main_valid_q && out_ready;

    if (out_fire) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // in_fire implies the skid is empty, so this never collides with the refill above.
    if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end

    in_ready_d = !skid_valid_d;
  end

  // Control flops: cleared by reset, so buffered beats are dropped and ready stays low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Payload flops: no reset, they only matter while the matching valid is set.
  always_ff @(posedge aclk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  // In bypass the registers are left dangling and get pruned by synthesis.
  assign out_valid = BYPASS ? in_valid  : main_valid_q;
  assign out_data  = BYPASS ? in_data   : main_data_q;
  assign in_ready  = BYPASS ? out_ready : in_ready_q;

endmodule

// File: rtl/axi_lite_reg_slice.sv
// AXI4-Lite register slice: one skid buffer per channel, per-channel bypass via REG_MASK {R,AR,B,W,AW}.
// Latency: 1 cycle per registered channel, 0 for bypassed ones; full throughput.
// Backpressure: every ready is a flop; a channel absorbs two stalled beats before dropping ready.
module axi_lite_reg_slice
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [4:0]  REG_MASK   = 5'b11111
) (
  input  logic      aclk,
  input  logic      aresetn,
  axi_lite_if.slave  s_if,
  axi_lite_if.master m_if
);

  localparam int unsigned AX_W = ADDR_WIDTH + PROT_W;
  localparam int unsigned W_W  = DATA_WIDTH + strb_w(DATA_WIDTH);
  localparam int unsigned B_W  = RESP_W;
  localparam int unsigned R_W  = DATA_WIDTH + RESP_W;

  logic [AX_W-1:0] aw_in_dat, aw_out_dat;
  logic [W_W-1:0]  w_in_dat,  w_out_dat;
  logic [B_W-1:0]  b_in_dat,  b_out_dat;
  logic [AX_W-1:0] ar_in_dat, ar_out_dat;
  logic [R_W-1:0]  r_in_dat,  r_out_dat;

  // Forward channels: upstream (s_if) to peripheral (m_if).
  assign aw_in_dat = {s_if.awaddr, s_if.awprot};
  assign {m_if.awaddr, m_if.awprot} = aw_out_dat;

  assign w_in_dat = {s_if.wdata, s_if.wstrb};
  assign {m_if.wdata, m_if.wstrb} = w_out_dat;

  assign ar_in_dat = {s_if.araddr, s_if.arprot};
  assign {m_if.araddr, m_if.arprot} = ar_out_dat;

  // Reverse channels: peripheral (m_if) back to upstream (s_if).
  assign b_in_dat   = m_if.bresp;
  assign s_if.bresp = b_out_dat;

  assign r_in_dat = {m_if.rdata, m_if.rresp};
  assign {s_if.rdata, s_if.rresp} = r_out_dat;

  axi_skid_buffer #(.WIDTH(AX_W), .BYPASS(!REG_MASK[0])) u_aw (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_if.awvalid),
    .in_ready  (s_if.awready),
    .in_data   (aw_in_dat),
    .out_valid (m_if.awvalid),
    .out_ready (m_if.awready),
    .out_data  (aw_out_dat)
  );

  axi_skid_buffer #(.WIDTH(W_W), .BYPASS(!REG_MASK[1])) u_w (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_if.wvalid),
    .in_ready  (s_if.wready),
    .in_data   (w_in_dat),
    .out_valid (m_if.wvalid),
    .out_ready (m_if.wready),
    .out_data  (w_out_dat)
  );

  axi_skid_buffer #(.WIDTH(B_W), .BYPASS(!REG_MASK[2])) u_b (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (m_if.bvalid),
    .in_ready  (m_if.bready),
    .in_data   (b_in_dat),
    .out_valid (s_if.bvalid),
    .out_ready (s_if.bready),
    .out_data  (b_out_dat)
  );

  axi_skid_buffer #(.WIDTH(AX_W), .BYPASS(!REG_MASK[3])) u_ar (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_if.arvalid),
    .in_ready  (s_if.arready),
    .in_data   (ar_in_dat),
    .out_valid (m_if.arvalid),
    .out_ready (m_if.arready),
    .out_data  (ar_out_dat)
  );

  axi_skid_buffer #(.WIDTH(R_W), .BYPASS(!REG_MASK[4])) u_r (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (m_if.rvalid),
    .in_ready  (m_if.rready),
    .in_data   (r_in_dat),
    .out_valid (s_if.rvalid),
    .out_ready (s_if.rready),
    .out_data  (r_out_dat)
  );

endmodule

// File: tb/tb_axi_lite_reg_slice.sv
// Directed bench for axi_lite_reg_slice: fully registered instance plus an R-bypass instance.
// Latency: n/a.
// Backpressure: driven explicitly per scenario.
module tb_axi_lite_reg_slice;
  import axi_lite_pkg::*;

  logic aclk;
  logic aresetn;
  int   vec_cnt;
  int   err_cnt;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0 ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0 ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1 ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1 ();

  axi_lite_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_MASK(5'b11111)) dut_reg (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_if    (s0),
    .m_if    (m0)
  );

  axi_lite_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_MASK(5'b01111)) dut_byp (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_if    (s1),
    .m_if    (m1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_idle();
    s0.awvalid = 0; s0.awaddr = '0; s0.awprot = '0;
    s0.wvalid  = 0; s0.wdata  = '0; s0.wstrb  = '0;
    s0.arvalid = 0; s0.araddr = '0; s0.arprot = '0;
    s0.bready  = 1; s0.rready = 1;
    m0.awready = 1; m0.wready = 1; m0.arready = 1;
    m0.bvalid  = 0; m0.bresp  = RESP_OKAY;
    m0.rvalid  = 0; m0.rdata  = '0; m0.rresp = RESP_OKAY;
    s1.awvalid = 0; s1.awaddr = '0; s1.awprot = '0;
    s1.wvalid  = 0; s1.wdata  = '0; s1.wstrb  = '0;
    s1.arvalid = 0; s1.araddr = '0; s1.arprot = '0;
    s1.bready  = 1; s1.rready = 1;
    m1.awready = 1; m1.wready = 1; m1.arready = 1;
    m1.bvalid  = 0; m1.bresp  = RESP_OKAY;
    m1.rvalid  = 0; m1.rdata  = '0; m1.rresp = RESP_OKAY;
  endtask

  task automatic test_reset();
    logic [4:0] rdy, vld;
    aresetn = 1'b1;
    drive_idle();
    #2 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    rdy = {s0.awready, s0.wready, m0.bready, s0.arready, m0.rready};
    vld = {m0.awvalid, m0.wvalid, s0.bvalid, m0.arvalid, s0.rvalid};
    vec_cnt++;
    if (rdy !== 5'b00000) begin err_cnt++; $display("FAIL reset_ready_low: got %b expected 00000", rdy); end
    vec_cnt++;
    if (vld !== 5'b00000) begin err_cnt++; $display("FAIL reset_valid_low: got %b expected 00000", vld); end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    rdy = {s0.awready, s0.wready, m0.bready, s0.arready, m0.rready};
    vld = {m0.awvalid, m0.wvalid, s0.bvalid, m0.arvalid, s0.rvalid};
    vec_cnt++;
    if (rdy !== 5'b11111) begin err_cnt++; $display("FAIL release_ready_high: got %b expected 11111", rdy); end
    vec_cnt++;
    if (vld !== 5'b00000) begin err_cnt++; $display("FAIL release_valid_low: got %b expected 00000", vld); end
  endtask

  task automatic test_aw_latency();
    s0.awvalid = 1; s0.awaddr = 32'h1000_0004; s0.awprot = 3'd0;
    #1;
    vec_cnt++;
    if ({s0.awready, m0.awvalid} !== 2'b10) begin
      err_cnt++; $display("FAIL aw_pre_edge: got rdy,vld=%b expected 10", {s0.awready, m0.awvalid});
    end
    @(posedge aclk); #1;
    s0.awvalid = 0;
    vec_cnt++;
    if ({s0.awready, m0.awvalid, m0.awaddr, m0.awprot} !== {1'b1, 1'b1, 32'h1000_0004, 3'd0}) begin
      err_cnt++; $display("FAIL aw_out: got rdy=%b vld=%b addr=%h prot=%h expected 1 1 10000004 0",
                          s0.awready, m0.awvalid, m0.awaddr, m0.awprot);
    end
    @(posedge aclk); #1;
    vec_cnt++;
    if ({s0.awready, m0.awvalid} !== 2'b10) begin
      err_cnt++; $display("FAIL aw_drained: got rdy,vld=%b expected 10", {s0.awready, m0.awvalid});
    end
  endtask

  task automatic test_stream_w();
    for (int i = 0; i < 8; i++) begin
      s0.wvalid = 1; s0.wdata = i; s0.wstrb = 4'hF;
      @(posedge aclk); #1;
      vec_cnt++;
      if ({s0.wready, m0.wvalid, m0.wdata, m0.wstrb} !== {1'b1, 1'b1, i[31:0], 4'hF}) begin
        err_cnt++; $display("FAIL w_stream[%0d]: got rdy=%b vld=%b data=%h strb=%h expected 1 1 %h f",
                            i, s0.wready, m0.wvalid, m0.wdata, m0.wstrb, i);
      end
    end
    s0.wvalid = 0;
    @(posedge aclk); #1;
    vec_cnt++;
    if (m0.wvalid !== 1'b0) begin err_cnt++; $display("FAIL w_stream_end: got vld=%b expected 0", m0.wvalid); end
  endtask

  task automatic test_backpressure_ar();
    m0.arready = 0;
    s0.arvalid = 1; s0.araddr = 32'h10;
    @(posedge aclk); #1;
    vec_cnt++;
    if ({s0.arready, m0.arvalid, m0.araddr} !== {1'b1, 1'b1, 32'h10}) begin
      err_cnt++; $display("FAIL ar_first: got rdy=%b vld=%b addr=%h expected 1 1 10", s0.arready, m0.arvalid, m0.araddr);
    end
    s0.araddr = 32'h20;
    @(posedge aclk); #1;
    vec_cnt++;
    if ({s0.arready, m0.arvalid, m0.araddr} !== {1'b0, 1'b1, 32'h10}) begin
      err_cnt++; $display("FAIL ar_skid_full: got rdy=%b vld=%b addr=%h expected 0 1 10", s0.arready, m0.arvalid, m0.araddr);
    end
    s0.araddr = 32'h30;
    for (int k = 0; k < 2; k++) begin
      @(posedge aclk); #1;
      vec_cnt++;
      if ({s0.arready, m0.arvalid, m0.araddr} !== {1'b0, 1'b1, 32'h10}) begin
        err_cnt++; $display("FAIL ar_stall[%0d]: got rdy=%b vld=%b addr=%h expected 0 1 10",
                            k, s0.arready, m0.arvalid, m0.araddr);
      end
    end
    m0.arready = 1;
    @(posedge aclk); #1;
    vec_cnt++;
    if ({s0.arready, m0.arvalid, m0.araddr} !== {1'b1, 1'b1, 32'h20}) begin
      err_cnt++; $display("FAIL ar_second: got rdy=%b vld=%b addr=%h expected 1 1 20", s0.arready, m0.arvalid, m0.araddr);
    end
    @(posedge aclk); #1;
    s0.arvalid = 0;
    vec_cnt++;
    if ({m0.arvalid, m0.araddr} !== {1'b1, 32'h30}) begin
      err_cnt++; $display("FAIL ar_third: got vld=%b addr=%h expected 1 30", m0.arvalid, m0.araddr);
    end
    @(posedge aclk); #1;
    vec_cnt++;
    if (m0.arvalid !== 1'b0) begin err_cnt++; $display("FAIL ar_drained: got vld=%b expected 0", m0.arvalid); end
  endtask

  task automatic test_reverse();
    // R: one beat, held two cycles by upstream, then taken.
    s0.rready = 0;
    m0.rvalid = 1; m0.rdata = 32'hDEAD_BEEF; m0.rresp = RESP_OKAY;
    @(posedge aclk); #1;
    m0.rvalid = 0; m0.rdata = 32'h0;
    vec_cnt++;
    if ({s0.rvalid, s0.rdata, s0.rresp} !== {1'b1, 32'hDEAD_BEEF, RESP_OKAY}) begin
      err_cnt++; $display("FAIL r_out: got vld=%b data=%h resp=%b expected 1 deadbeef 00", s0.rvalid, s0.rdata, s0.rresp);
    end
    @(posedge aclk); #1;
    vec_cnt++;
    if ({s0.rvalid, s0.rdata, s0.rresp} !== {1'b1, 32'hDEAD_BEEF, RESP_OKAY}) begin
      err_cnt++; $display("FAIL r_stable: got vld=%b data=%h resp=%b expected 1 deadbeef 00", s0.rvalid, s0.rdata, s0.rresp);
    end
    s0.rready = 1;
    @(posedge aclk); #1;
    s0.rready = 0;
    vec_cnt++;
    if (s0.rvalid !== 1'b0) begin err_cnt++; $display("FAIL r_once: got vld=%b expected 0", s0.rvalid); end
    // B: SLVERR, stalled one cycle then taken.
    s0.rready = 1;
    s0.bready = 0;
    m0.bvalid = 1; m0.bresp = RESP_SLVERR;
    @(posedge aclk); #1;
    m0.bvalid = 0; m0.bresp = RESP_OKAY;
    vec_cnt++;
    if ({s0.bvalid, s0.bresp} !== {1'b1, RESP_SLVERR}) begin
      err_cnt++; $display("FAIL b_out: got vld=%b resp=%b expected 1 10", s0.bvalid, s0.bresp);
    end
    @(posedge aclk); #1;
    vec_cnt++;
    if ({s0.bvalid, s0.bresp} !== {1'b1, RESP_SLVERR}) begin
      err_cnt++; $display("FAIL b_stable: got vld=%b resp=%b expected 1 10", s0.bvalid, s0.bresp);
    end
    s0.bready = 1;
    @(posedge aclk); #1;
    vec_cnt++;
    if (s0.bvalid !== 1'b0) begin err_cnt++; $display("FAIL b_once: got vld=%b expected 0", s0.bvalid); end
  endtask

  task automatic test_mid_reset();
    logic [4:0] vld;
    m0.awready = 0; s0.rready = 0;
    s0.awvalid = 1; s0.awaddr = 32'hA1;
    m0.rvalid  = 1; m0.rdata  = 32'h11; m0.rresp = RESP_OKAY;
    @(posedge aclk); #1;
    s0.awaddr = 32'hA2; m0.rdata = 32'h22;
    @(posedge aclk); #1;
    s0.awvalid = 0; m0.rvalid = 0;
    vec_cnt++;
    if ({s0.awready, m0.rready, m0.awaddr, s0.rdata} !== {1'b0, 1'b0, 32'hA1, 32'h11}) begin
      err_cnt++; $display("FAIL mr_full: got awrdy=%b rrdy=%b awaddr=%h rdata=%h expected 0 0 a1 11",
                          s0.awready, m0.rready, m0.awaddr, s0.rdata);
    end
    aresetn = 1'b0;
    #1;
    vld = {m0.awvalid, m0.wvalid, s0.bvalid, m0.arvalid, s0.rvalid};
    vec_cnt++;
    if (vld !== 5'b00000) begin err_cnt++; $display("FAIL mr_async_clear: got %b expected 00000", vld); end
    @(posedge aclk); #1;
    vld = {m0.awvalid, m0.wvalid, s0.bvalid, m0.arvalid, s0.rvalid};
    vec_cnt++;
    if ({vld, s0.awready, m0.rready} !== 7'b0000000) begin
      err_cnt++; $display("FAIL mr_in_reset: got vld=%b awrdy=%b rrdy=%b expected 00000 0 0", vld, s0.awready, m0.rready);
    end
    aresetn = 1'b1; m0.awready = 1; s0.rready = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk); #1;
      vec_cnt++;
      if ({m0.awvalid, s0.rvalid, s0.awready, m0.rready} !== 4'b0011) begin
        err_cnt++; $display("FAIL mr_no_stale[%0d]: got awvld,rvld,awrdy,rrdy=%b expected 0011",
                            k, {m0.awvalid, s0.rvalid, s0.awready, m0.rready});
      end
    end
    s0.awvalid = 1; s0.awaddr = 32'hB0;
    m0.rvalid  = 1; m0.rdata  = 32'h33;
    @(posedge aclk); #1;
    s0.awvalid = 0; m0.rvalid = 0;
    vec_cnt++;
    if ({m0.awvalid, m0.awaddr, s0.rvalid, s0.rdata} !== {1'b1, 32'hB0, 1'b1, 32'h33}) begin
      err_cnt++; $display("FAIL mr_fresh: got awvld=%b awaddr=%h rvld=%b rdata=%h expected 1 b0 1 33",
                          m0.awvalid, m0.awaddr, s0.rvalid, s0.rdata);
    end
    @(posedge aclk); #1;
    vec_cnt++;
    if ({m0.awvalid, s0.rvalid} !== 2'b00) begin
      err_cnt++; $display("FAIL mr_fresh_done: got %b expected 00", {m0.awvalid, s0.rvalid});
    end
  endtask

  task automatic test_bypass();
    // R on dut_byp is wired straight through; AW is still registered.
    m1.rvalid = 1; m1.rdata = 32'hCAFE_F00D; m1.rresp = RESP_DECERR;
    s1.rready = 0;
    s1.awvalid = 1; s1.awaddr = 32'h44;
    #1;
    vec_cnt++;
    if ({s1.rvalid, s1.rdata, s1.rresp} !== {1'b1, 32'hCAFE_F00D, RESP_DECERR}) begin
      err_cnt++; $display("FAIL byp_r_fwd: got vld=%b data=%h resp=%b expected 1 cafef00d 11", s1.rvalid, s1.rdata, s1.rresp);
    end
    vec_cnt++;
    if (m1.rready !== 1'b0) begin err_cnt++; $display("FAIL byp_rready_lo: got %b expected 0", m1.rready); end
    vec_cnt++;
    if (m1.awvalid !== 1'b0) begin err_cnt++; $display("FAIL byp_aw_registered: got %b expected 0", m1.awvalid); end
    s1.rready = 1;
    #1;
    vec_cnt++;
    if (m1.rready !== 1'b1) begin err_cnt++; $display("FAIL byp_rready_hi: got %b expected 1", m1.rready); end
    m1.rvalid = 0; m1.rdata = 32'h1234_5678;
    #1;
    vec_cnt++;
    if ({s1.rvalid, s1.rdata} !== {1'b0, 32'h1234_5678}) begin
      err_cnt++; $display("FAIL byp_r_drop: got vld=%b data=%h expected 0 12345678", s1.rvalid, s1.rdata);
    end
    @(posedge aclk); #1;
    s1.awvalid = 0;
    vec_cnt++;
    if ({m1.awvalid, m1.awaddr} !== {1'b1, 32'h44}) begin
      err_cnt++; $display("FAIL byp_aw_out: got vld=%b addr=%h expected 1 44", m1.awvalid, m1.awaddr);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_aw_latency();
    test_stream_w();
    test_backpressure_ar();
    test_reverse();
    test_mid_reset();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
